warp_xwb_arbiter: RTL
=====================

# warp_xwb_arbiter

Writeback arbiter for the scalar integer pipeline. It collects results from up to NUM_SRC fixed- or variable-latency integer execution units, for example the arith, logic, multiply and divide units, and buffers each source in a small FIFO. Each cycle it grants up to two buffered results, round-robin, onto the two write ports of the integer register file. It is the "external buffering" that lets execution units assume writeback always accepts a result.

## Interface
Parameters:
- NUM_SRC, 4: number of result sources, 2..8.
- DEPTH, 2: entries per source FIFO; power of two, ≥2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_src_valid  in  NUM_SRC  source s presents a result this cycle.
- i_src_rd  in  5*NUM_SRC  destination register; source s occupies bits [5s+4:5s].
- i_src_data  in  64*NUM_SRC  result data; source s occupies bits [64s+63:64s].
- o_src_ready  out  NUM_SRC  source s FIFO has a free entry; issue logic must not issue to unit s when low.
- o_rd1_wen / o_rd2_wen  out  1  register file write enables.
- o_rd1_addr / o_rd2_addr  out  5  write addresses.
- o_rd1_wdata / o_rd2_wdata  out  64  write data.
- o_overflow  out  1  sticky; a push arrived while the target FIFO was full.
- o_busy  out  1  some FIFO is non-empty or a write enable is high.

## Operation
- Push: when i_src_valid[s] and o_src_ready[s], append {rd, data} to FIFO s.
  - If i_src_valid[s] is high while o_src_ready[s] is low, the result is dropped and o_overflow is set. o_overflow stays set until reset.
- o_src_ready[s] = (count[s] < DEPTH), computed from the registered count only. A same-cycle pop does not raise ready.
- Arbitration: each cycle, scan sources in order ptr, ptr+1, … (mod NUM_SRC) for non-empty FIFOs.
  - The first hit wins port 1. The next hit wins port 2.
  - A port-2 candidate whose head rd equals port 1's head rd (both non-zero) is skipped for that cycle, and the scan continues. This guarantees rd1_addr ≠ rd2_addr whenever both enables are high.
- Each winner pops its head.
- A head with rd = 0 still wins and pops, but its port's wen stays 0. The entry is discarded.
- Pointer update: ptr ← (index of last granted source + 1) mod NUM_SRC. It is unchanged if nothing was granted.
- Output registers load every cycle:
  - wen = granted and rd ≠ 0.
  - addr and data = winner's head when granted; otherwise they are 0.
- Order within one source is preserved, because each FIFO is strictly in order. There is no ordering guarantee across sources; WAW across units is the issue logic's responsibility.
- FIFO pointers wrap modulo DEPTH. Full is count = DEPTH; empty is count = 0.
- Push and pop on the same FIFO in the same cycle: the count is unchanged, and both operations take effect.

## Timing
- Latency: a result pushed at the edge ending cycle t is eligible in cycle t+1 and appears on o_rdX_* in cycle t+2 if granted immediately. There is no push-to-output bypass.
- Throughput: 2 writes per cycle aggregate, at most 1 per source per cycle.
- Starvation bound: a non-empty FIFO is granted within ceil(NUM_SRC/2) cycles, plus 1 extra cycle when an rd-conflict skip occurs.
- Reset (i_rst high at an edge) produces:
  - all FIFOs empty, ptr = 0;
  - o_rd1/2_wen = 0, addr = 0, wdata = 0;
  - o_overflow = 0, o_busy = 0.
- o_src_ready is forced to 0 during any cycle in which i_rst is high, and is all-ones in the first cycle after reset.
- Reset mid-operation discards all buffered results with no writes. Pushes sampled in the reset cycle are ignored and do not set o_overflow.

## Test plan
- Single result: reset, then source 0 pushes rd=5, data=0xDEAD_BEEF in cycle 1.
  - Required: o_rd1_wen=1, addr=5, wdata=0xDEADBEEF in cycle 3; o_rd2_wen=0; o_busy falls in cycle 4.
- Four-way collision: all 4 sources push rd=1..4 in the same cycle.
  - Required: cycle t+2 writes sources 0,1 (rd 1,2) on ports 1,2; cycle t+3 writes sources 2,3 (rd 3,4); ptr returns to 0.
- Same-rd conflict: sources 1 and 2 both push rd=7 (data A, B) with ptr=1.
  - Required: port 1 writes A, port 2 idle; next cycle port 1 writes B. Enables are never both high with addr 7.
- x0 discard: source 3 pushes rd=0 data=0xFF.
  - Required: the entry pops and no wen is asserted.
  - Source 3 pushing rd=0 then rd=9 back-to-back: the rd=9 result is written one cycle later.
- Backpressure/overflow with DEPTH=2: a port-2 rd conflict holds source 1 for one cycle while source 0 pushes every cycle.
  - Required: o_src_ready[0]=0 exactly while count=2.
  - Forcing a push while not ready: o_overflow=1 and stays 1, and the dropped data never appears.
- Reset mid-stream: assert i_rst for 1 cycle with 3 entries buffered.
  - Required: no writes occur afterward, all outputs are 0 the next cycle, and o_src_ready is all-ones the following cycle.

Source files
------------

// File: rtl/warp_xwb_arbiter.sv
// warp_xwb_arbiter
// ----------------
// Writeback arbiter for the scalar integer pipeline. Each execution unit
// (source) owns a small in-order FIFO of {rd, data} results. Every cycle
// the two integer register-file write ports each receive at most one
// buffered result. Sources are scanned round-robin, starting at a rotating
// pointer.
//
// Ports
//   i_clk         clock
//   i_rst         synchronous, active-high reset
//   i_src_valid   [NUM_SRC]     source s presents a result this cycle
//   i_src_rd      [5*NUM_SRC]   destination register, source s at [5s+4:5s]
//   i_src_data    [64*NUM_SRC]  result data, source s at [64s+63:64s]
//   o_src_ready   [NUM_SRC]     FIFO s has a free entry
//   o_rd1_*/o_rd2_*             registered register-file write ports
//   o_overflow                  sticky: a push was dropped on a full FIFO
//   o_busy                      a FIFO holds data or a write enable is high
//
// Handshake: a result from source s is accepted on a rising edge where
// i_src_valid[s] and o_src_ready[s] are both high. o_src_ready[s] depends
// only on the registered occupancy, so a pop in the same cycle never
// raises it. If valid is high while ready is low, the result is dropped
// and o_overflow is set. Issue logic must not let that happen.

module warp_xwb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_SRC-1:0]    i_src_valid,
  input  logic [5*NUM_SRC-1:0]  i_src_rd,
  input  logic [64*NUM_SRC-1:0] i_src_data,
  output logic [NUM_SRC-1:0]    o_src_ready,
  output logic                  o_rd1_wen,
  output logic [4:0]            o_rd1_addr,
  output logic [63:0]           o_rd1_wdata,
  output logic                  o_rd2_wen,
  output logic [4:0]            o_rd2_addr,
  output logic [63:0]           o_rd2_wdata,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(NUM_SRC);
  localparam int EW = 69;  // {rd[4:0], data[63:0]}

  // Per-source FIFO storage and bookkeeping
  logic [EW-1:0] mem     [NUM_SRC][DEPTH];
  logic [PW-1:0] wr_ptr  [NUM_SRC];
  logic [PW-1:0] rd_ptr  [NUM_SRC];
  logic [CW-1:0] count   [NUM_SRC];
  logic [4:0]    head_rd   [NUM_SRC];
  logic [63:0]   head_data [NUM_SRC];

  logic [NUM_SRC-1:0] ready_int;
  logic [NUM_SRC-1:0] non_empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  // Round-robin arbitration state and results
  logic [SW-1:0] arb_ptr;
  logic [SW-1:0] arb_ptr_nxt;
  logic          g1_vld, g2_vld;
  logic [SW-1:0] g1_idx, g2_idx;
  logic [4:0]    g1_rd, g2_rd;
  logic [63:0]   g1_data, g2_data;
  int            scan;
  int            last;

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      head_rd[s]   = mem[s][rd_ptr[s]][68:64];
      head_data[s] = mem[s][rd_ptr[s]][63:0];
      non_empty[s] = (count[s] != '0);
      ready_int[s] = (count[s] < CW'(DEPTH));
      push[s]      = i_src_valid[s] & ready_int[s];
    end
  end

  // Ready is forced low while reset is asserted. Pushes in the reset
  // cycle are ignored by the sequential logic anyway.
  assign o_src_ready = i_rst ? '0 : ready_int;
  assign o_busy      = (|non_empty) | o_rd1_wen | o_rd2_wen;

  // Scan sources starting at arb_ptr. The first non-empty source gets
  // port 1. The next non-empty source gets port 2, unless its head would
  // write the same non-zero register as port 1. A skipped source stays
  // queued and is reconsidered in the next cycle.
  always_comb begin
    g1_vld  = 1'b0;
    g2_vld  = 1'b0;
    g1_idx  = '0;
    g2_idx  = '0;
    g1_rd   = '0;
    g2_rd   = '0;
    g1_data = '0;
    g2_data = '0;
    scan    = 0;
    last    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan = int'(arb_ptr) + k;
      if (scan >= NUM_SRC) scan = scan - NUM_SRC;
      if (non_empty[scan]) begin
        if (!g1_vld) begin
          g1_vld  = 1'b1;
          g1_idx  = SW'(scan);
          g1_rd   = head_rd[scan];
          g1_data = head_data[scan];
        end else if (!g2_vld &&
                     !((head_rd[scan] != 5'd0) && (head_rd[scan] == g1_rd))) begin
          g2_vld  = 1'b1;
          g2_idx  = SW'(scan);
          g2_rd   = head_rd[scan];
          g2_data = head_data[scan];
        end
      end
    end

    pop = '0;
    if (g1_vld) pop[g1_idx] = 1'b1;
    if (g2_vld) pop[g2_idx] = 1'b1;

    // The pointer moves past the last granted source. It holds when idle.
    arb_ptr_nxt = arb_ptr;
    if (g1_vld) begin
      last = g2_vld ? int'(g2_idx) : int'(g1_idx);
      arb_ptr_nxt = (last + 1 == NUM_SRC) ? '0 : SW'(last + 1);
    end
  end

  // FIFO storage has no reset. Only entries covered by count are ever read.
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!i_rst && push[s]) begin
        mem[s][wr_ptr[s]] <= {i_src_rd[5*s +: 5], i_src_data[64*s +: 64]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
      arb_ptr     <= '0;
      o_rd1_wen   <= 1'b0;
      o_rd1_addr  <= '0;
      o_rd1_wdata <= '0;
      o_rd2_wen   <= 1'b0;
      o_rd2_addr  <= '0;
      o_rd2_wdata <= '0;
      o_overflow  <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
        // A simultaneous push and pop leaves the count unchanged.
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + CW'(1);
          2'b01:   count[s] <= count[s] - CW'(1);
          default: count[s] <= count[s];
        endcase
      end
      arb_ptr <= arb_ptr_nxt;

      // A granted head with rd = 0 is popped and discarded. Its enable
      // stays low.
      o_rd1_wen   <= g1_vld && (g1_rd != 5'd0);
      o_rd1_addr  <= g1_vld ? g1_rd : 5'd0;
      o_rd1_wdata <= g1_vld ? g1_data : 64'd0;
      o_rd2_wen   <= g2_vld && (g2_rd != 5'd0);
      o_rd2_addr  <= g2_vld ? g2_rd : 5'd0;
      o_rd2_wdata <= g2_vld ? g2_data : 64'd0;

      if (|(i_src_valid & ~ready_int)) o_overflow <= 1'b1;
    end
  end

endmodule
